// File: rtl/instr_sequencer.sv
// TinyALU instruction unit: writable program memory, operand register file and
// an issue FSM that hands loads/stores to the memory interface and ops to the ALU.
module instr_sequencer #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 14,
    parameter int IMEM_DEPTH = 1024,
    parameter int NUM_REGS   = 4,
    parameter int TIMEOUT    = 255,
    localparam int RI_W      = $clog2(NUM_REGS),
    localparam int PC_W      = $clog2(IMEM_DEPTH),
    localparam int INSTR_W   = 4 + ADDR_W + 2 * RI_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                imem_we,
    input  logic [PC_W-1:0]     imem_waddr,
    input  logic [INSTR_W-1:0]  imem_wdata,
    output logic                mem_load,
    output logic                mem_store,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [2*DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_done,
    output logic                alu_start,
    output logic [2:0]          alu_op,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    input  logic [2*DATA_W-1:0] alu_result,
    input  logic                alu_done,
    output logic                busy,
    output logic                halted,
    output logic [1:0]          error,
    output logic [PC_W-1:0]     pc
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [3:0] OPC_NOP   = 4'h0;
    localparam logic [3:0] OPC_ADD   = 4'h1;
    localparam logic [3:0] OPC_AND   = 4'h2;
    localparam logic [3:0] OPC_XOR   = 4'h3;
    localparam logic [3:0] OPC_MUL   = 4'h4;
    localparam logic [3:0] OPC_LOAD  = 4'h8;
    localparam logic [3:0] OPC_STORE = 4'h9;
    localparam logic [3:0] OPC_HALT  = 4'hF;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_LD_WAIT, S_ST_WAIT, S_ALU_WAIT, S_HALT
    } state_t;

    state_t              state_reg, state_next;
    logic [PC_W-1:0]     pc_reg, pc_next;
    logic [1:0]          error_reg, error_next;
    logic [2*DATA_W-1:0] res_reg, res_next;
    logic [WD_W-1:0]     wdog_reg, wdog_next;
    logic [DATA_W-1:0]   regs_reg [NUM_REGS];
    logic                reg_we;
    logic [NUM_REGS-1:0] reg_wen;

    logic [INSTR_W-1:0]  imem [IMEM_DEPTH];
    logic [INSTR_W-1:0]  instr_reg;

    logic [3:0]          opc;
    logic [ADDR_W-1:0]   addr;
    logic [RI_W-1:0]     ra;
    logic [RI_W-1:0]     rb;

    assign opc  = instr_reg[INSTR_W-1 -: 4];
    assign addr = instr_reg[2*RI_W +: ADDR_W];
    assign ra   = instr_reg[RI_W +: RI_W];
    assign rb   = instr_reg[0 +: RI_W];

    assign busy   = (state_reg != S_IDLE) && (state_reg != S_HALT);
    assign halted = (state_reg == S_HALT);
    assign error  = error_reg;
    assign pc     = pc_reg;

    // Program memory: writes only while stopped, registered read during FETCH.
    always_ff @(posedge clk) begin
        if (imem_we && !busy) begin
            imem[imem_waddr] <= imem_wdata;
        end
        if (state_reg == S_FETCH) begin
            instr_reg <= imem[pc_reg];
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_wen
        assign reg_wen[gi] = reg_we && (ra == RI_W'(gi));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_wen[i]) begin
                    regs_reg[i] <= mem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            pc_reg    <= '0;
            error_reg <= ERR_NONE;
            res_reg   <= '0;
            wdog_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            error_reg <= error_next;
            res_reg   <= res_next;
            wdog_reg  <= wdog_next;
        end
    end

    // Requests are decoded from the state, so a reset drops them immediately.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        error_next = error_reg;
        res_next   = res_reg;
        wdog_next  = wdog_reg;
        reg_we     = 1'b0;
        mem_load   = 1'b0;
        mem_store  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        alu_start  = 1'b0;
        alu_op     = '0;
        alu_a      = '0;
        alu_b      = '0;
        case (state_reg)
            S_IDLE, S_HALT: begin
                if (run) begin
                    state_next = S_FETCH;
                    pc_next    = '0;
                    error_next = ERR_NONE;
                end
            end
            S_FETCH: state_next = S_EXEC;
            S_EXEC: begin
                wdog_next = '0;
                case (opc)
                    OPC_NOP: begin
                        pc_next    = pc_reg + 1'b1;
                        state_next = S_FETCH;
                    end
                    OPC_ADD, OPC_AND, OPC_XOR, OPC_MUL: begin
                        alu_start  = 1'b1;
                        alu_op     = opc[2:0];
                        alu_a      = regs_reg[ra];
                        alu_b      = regs_reg[rb];
                        state_next = S_ALU_WAIT;
                    end
                    OPC_LOAD: begin
                        mem_load   = 1'b1;
                        mem_addr   = addr;
                        state_next = S_LD_WAIT;
                    end
                    OPC_STORE: begin
                        mem_store  = 1'b1;
                        mem_addr   = addr;
                        mem_wdata  = res_reg;
                        state_next = S_ST_WAIT;
                    end
                    OPC_HALT: state_next = S_HALT;
                    default: begin
                        error_next = ERR_ILLEGAL;
                        state_next = S_HALT;
                    end
                endcase
            end
            S_LD_WAIT, S_ST_WAIT: begin
                mem_load  = (state_reg == S_LD_WAIT);
                mem_store = (state_reg == S_ST_WAIT);
                mem_addr  = addr;
                mem_wdata = (state_reg == S_ST_WAIT) ? res_reg : '0;
                if (mem_done) begin
                    reg_we     = (state_reg == S_LD_WAIT);
                    pc_next    = pc_reg + 1'b1;
                    state_next = S_FETCH;
                end else if (wdog_reg == WD_LAST) begin
                    error_next = ERR_TIMEOUT;
                    state_next = S_HALT;
                end else begin
                    wdog_next = wdog_reg + 1'b1;
                end
            end
            S_ALU_WAIT: begin
                alu_op = opc[2:0];
                alu_a  = regs_reg[ra];
                alu_b  = regs_reg[rb];
                if (alu_done) begin
                    res_next   = alu_result;
                    pc_next    = pc_reg + 1'b1;
                    state_next = S_FETCH;
                end else if (wdog_reg == WD_LAST) begin
                    error_next = ERR_TIMEOUT;
                    state_next = S_HALT;
                end else begin
                    wdog_next = wdog_reg + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: an ISA-level interpreter predicts every memory/ALU
// request of randomized and directed programs; the bench acts as memory and ALU.
module tb_instr_sequencer;
    localparam int DATA_W = 8, ADDR_W = 14, IMEM_DEPTH = 1024, NUM_REGS = 4, TIMEOUT = 255;
    localparam int RI_W = 2, PC_W = 10, INSTR_W = 22;

    logic clk = 1'b0;
    logic reset, run, imem_we, mem_done, alu_done;
    logic [PC_W-1:0] imem_waddr;
    logic [INSTR_W-1:0] imem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [2*DATA_W-1:0] alu_result;
    logic mem_load, mem_store, alu_start, busy, halted;
    logic [ADDR_W-1:0] mem_addr;
    logic [2*DATA_W-1:0] mem_wdata;
    logic [2:0] alu_op;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [1:0] error;
    logic [PC_W-1:0] pc;

    instr_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMEM_DEPTH(IMEM_DEPTH),
                      .NUM_REGS(NUM_REGS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .run(run), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .mem_load(mem_load), .mem_store(mem_store),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_done(mem_done), .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a),
        .alu_b(alu_b), .alu_result(alu_result), .alu_done(alu_done), .busy(busy),
        .halted(halted), .error(error), .pc(pc));

    always #5 clk = ~clk;

    typedef struct {
        int kind;                 // 0 load, 1 store, 2 alu
        logic [ADDR_W-1:0] addr;
        logic [15:0] data;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } txn_t;

    int n_cmp = 0, n_bad = 0, n_txn = 0;
    logic [INSTR_W-1:0] prog [IMEM_DEPTH];
    logic [INSTR_W-1:0] pq [$];
    logic [15:0] dmem [int];
    logic [7:0] mregs [NUM_REGS];
    logic [15:0] mres;
    txn_t expq [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [INSTR_W-1:0] ins(input logic [3:0] opc, input int a, input int ra, input int rb);
        return {opc, ADDR_W'(a), RI_W'(ra), RI_W'(rb)};
    endfunction

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd1: return 16'(a) + 16'(b);
            3'd2: return 16'(a & b);
            3'd3: return 16'(a ^ b);
            3'd4: return 16'(a) * 16'(b);
            default: return 16'h0;
        endcase
    endfunction

    function automatic logic [15:0] mread(input int a);
        if (dmem.exists(a)) return dmem[a];
        return 16'h0;
    endfunction

    // Interpreter: walks the program from pc 0, queues the expected requests.
    task automatic model_run(output int fpc, output logic [1:0] ferr);
        int p = 0;
        logic [INSTR_W-1:0] w;
        logic [3:0] opc;
        int a, ra, rb;
        txn_t t;
        expq.delete();
        fpc = -1; ferr = 2'b11;
        for (int step = 0; step < 4096; step++) begin
            w = prog[p];
            opc = w[21:18]; a = int'(w[17:4]); ra = int'(w[3:2]); rb = int'(w[1:0]);
            t.kind = 0; t.addr = ADDR_W'(a); t.data = 0; t.op = opc[2:0]; t.a = 0; t.b = 0;
            case (opc)
                4'h0: ;
                4'h1, 4'h2, 4'h3, 4'h4: begin
                    t.kind = 2; t.a = mregs[ra]; t.b = mregs[rb];
                    t.data = alu_fn(opc[2:0], t.a, t.b); mres = t.data; expq.push_back(t);
                end
                4'h8: begin
                    t.data = {8'h00, 8'(mread(a))}; mregs[ra] = t.data[7:0]; expq.push_back(t);
                end
                4'h9: begin
                    t.kind = 1; t.data = mres; dmem[a] = mres; expq.push_back(t);
                end
                4'hF: begin fpc = p; ferr = 2'b00; return; end
                default: begin fpc = p; ferr = 2'b01; return; end
            endcase
            p = (p + 1) % IMEM_DEPTH;
        end
    endtask

    task automatic load_prog();
        foreach (pq[i]) begin
            @(negedge clk);
            imem_we = 1'b1; imem_waddr = PC_W'(i); imem_wdata = pq[i]; prog[i] = pq[i];
        end
        @(negedge clk);
        imem_we = 1'b0;
    endtask

    task automatic model_reset();
        foreach (mregs[i]) mregs[i] = 8'h00;
        mres = 16'h0;
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_req"}, {mem_load, mem_store, alu_start}, 0);
        check({tag, "_maddr"}, mem_addr, 0);
        check({tag, "_mwdata"}, mem_wdata, 0);
        check({tag, "_alu"}, {alu_op, alu_a, alu_b}, 0);
        check({tag, "_status"}, {busy, halted, error}, 0);
        check({tag, "_pc"}, pc, 0);
    endtask

    // Runs the loaded program to HALT, acting as memory and ALU with random latency.
    task automatic exec_prog(input bit poke);
        int fpc, mcnt = 0, acnt = 0;
        logic [1:0] ferr;
        bit mem_pend = 0, mem_drop = 0, alu_pend = 0, alu_first = 0;
        txn_t mcur, acur;
        model_run(fpc, ferr);
        @(negedge clk);
        run = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            run = 1'b0; imem_we = 1'b0; mem_done = 1'b0; alu_done = 1'b0;
            if (cyc == 0) begin
                check("start_pc", pc, 0);
                check("start_err", error, 0);
                check("start_flags", {busy, halted}, 2'b10);
            end
            if (poke && cyc == 3) begin
                imem_we = 1'b1; imem_waddr = 1; imem_wdata = ins(4'hF, 0, 0, 0); run = 1'b1;
            end
            if (halted) break;
            if (mem_pend) begin
                check("mem_req_hold", {mem_load, mem_store}, (mcur.kind == 0) ? 2'b10 : 2'b01);
                check("mem_addr_hold", mem_addr, mcur.addr);
                mcnt--;
                if (mcnt == 0) begin
                    mem_done = 1'b1; mem_rdata = mcur.data[7:0]; mem_pend = 0; mem_drop = 1;
                end else if ($urandom_range(0, 2) == 0) begin
                    alu_done = 1'b1; alu_result = 16'($urandom);
                end
            end else if (mem_drop) begin
                check("mem_req_drop", {mem_load, mem_store}, 0);
                mem_drop = 0;
            end else if (mem_load || mem_store) begin
                if (expq.size() == 0) check("unexpected_mem_req", {mem_load, mem_store}, 0);
                else begin
                    mcur = expq.pop_front();
                    check("mem_kind", {mem_load, mem_store}, (mcur.kind == 0) ? 2'b10 : 2'b01);
                    check("mem_addr", mem_addr, mcur.addr);
                    if (mcur.kind == 1) check("st_data", mem_wdata, mcur.data);
                    $display("txn %0d: pc=%0d %s addr=0x%03h data=0x%04h", n_txn++, pc,
                             mem_load ? "LOAD " : "STORE", mem_addr, mem_load ? mcur.data : mem_wdata);
                    mem_pend = 1; mcnt = $urandom_range(1, 4);
                end
            end
            if (alu_pend) begin
                if (alu_first) check("alu_start_1cyc", alu_start, 0);
                alu_first = 0;
                check("alu_hold", {alu_op, alu_a, alu_b}, {acur.op, acur.a, acur.b});
                acnt--;
                if (acnt == 0) begin
                    alu_done = 1'b1; alu_result = acur.data; alu_pend = 0;
                end else if ($urandom_range(0, 2) == 0) begin
                    mem_done = 1'b1; mem_rdata = 8'($urandom);
                end
            end else if (alu_start) begin
                if (expq.size() == 0) check("unexpected_alu_req", alu_start, 0);
                else begin
                    acur = expq.pop_front();
                    check("alu_kind", acur.kind, 2);
                    check("alu_issue", {alu_op, alu_a, alu_b}, {acur.op, acur.a, acur.b});
                    $display("txn %0d: pc=%0d ALU   op=%0d a=0x%02h b=0x%02h res=0x%04h", n_txn++, pc,
                             alu_op, alu_a, alu_b, acur.data);
                    alu_pend = 1; alu_first = 1; acnt = $urandom_range(1, 4);
                end
            end
        end
        check("halt_reached", halted, 1);
        check("end_pc", pc, fpc);
        check("end_err", error, ferr);
        check("end_busy", busy, 0);
        check("txn_left", expq.size(), 0);
    endtask

    initial begin
        int n, loads;
        bit seen, pend;
        logic [3:0] opc;
        reset = 1'b1; run = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        mem_rdata = '0; mem_done = 1'b0; alu_result = '0; alu_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outs_zero("rst");
        reset = 1'b0;
        @(negedge clk);
        check_outs_zero("idle");

        // LOAD/LOAD/ADD/STORE/HALT
        dmem[16'h10] = 16'h0025; dmem[16'h11] = 16'h0013;
        pq.delete();
        pq.push_back(ins(4'h8, 'h10, 0, 0)); pq.push_back(ins(4'h8, 'h11, 1, 0));
        pq.push_back(ins(4'h1, 0, 0, 1));    pq.push_back(ins(4'h9, 'h12, 0, 0));
        pq.push_back(ins(4'hF, 0, 0, 0));
        load_prog(); exec_prog(0);

        // MUL 0xFF*0xFF
        dmem[16'h13] = 16'h00FF; dmem[16'h14] = 16'h00FF;
        pq.delete();
        pq.push_back(ins(4'h8, 'h13, 2, 0)); pq.push_back(ins(4'h8, 'h14, 3, 0));
        pq.push_back(ins(4'h4, 0, 2, 3));    pq.push_back(ins(4'h9, 'h15, 0, 0));
        pq.push_back(ins(4'hF, 0, 0, 0));
        load_prog(); exec_prog(0);

        // Illegal opcode at pc 2
        pq.delete();
        pq.push_back(ins(4'h8, 'h10, 0, 0)); pq.push_back(ins(4'h3, 0, 0, 2));
        pq.push_back(ins(4'h5, 'h20, 1, 1)); pq.push_back(ins(4'hF, 0, 0, 0));
        load_prog(); exec_prog(0);

        // Watchdog on a withheld mem_done
        pq.delete();
        pq.push_back(ins(4'h8, 'h20, 0, 0)); pq.push_back(ins(4'hF, 0, 0, 0));
        load_prog();
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        n = 0;
        for (int c = 0; c < 600 && !halted; c++) begin
            if (mem_load) n++;
            @(negedge clk);
        end
        check("to_load_cycles", n, TIMEOUT + 1);
        check("to_err", error, 2'b10);
        check("to_flags", {halted, busy, mem_load}, 3'b100);
        exec_prog(0);

        // Writes and run pulses while busy are ignored
        pq.delete();
        pq.push_back(ins(4'h8, 'h11, 1, 0)); pq.push_back(ins(4'h2, 0, 1, 0));
        pq.push_back(ins(4'h9, 'h30, 0, 0)); pq.push_back(ins(4'hF, 0, 0, 0));
        load_prog(); exec_prog(1); exec_prog(0);

        // Reset during ALU_WAIT, then a late alu_done
        pq.delete();
        pq.push_back(ins(4'h1, 0, 0, 1)); pq.push_back(ins(4'hF, 0, 0, 0));
        load_prog();
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (alu_start) begin seen = 1; break; end
            @(negedge clk);
        end
        check("rst_alu_issued", seen, 1);
        @(negedge clk);
        check("rst_alu_wait", {alu_start, busy}, 2'b01);
        reset = 1'b1;
        #1;
        check_outs_zero("rst_async");
        @(negedge clk); reset = 1'b0;
        @(negedge clk); alu_done = 1'b1; alu_result = 16'hBEEF; mem_done = 1'b1; mem_rdata = 8'h77;
        @(negedge clk); alu_done = 1'b0; mem_done = 1'b0;
        check_outs_zero("rst_after");
        model_reset();
        pq.delete();
        pq.push_back(ins(4'h9, 'h40, 0, 0)); pq.push_back(ins(4'h1, 0, 0, 1));
        pq.push_back(ins(4'h9, 'h41, 0, 0)); pq.push_back(ins(4'hF, 0, 0, 0));
        load_prog(); exec_prog(0);

        // Randomized programs
        for (int a = 0; a < 16; a++) dmem[a] = 16'($urandom);
        for (int t = 0; t < 10; t++) begin
            pq.delete();
            n = $urandom_range(3, 12);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 9))
                    0: opc = 4'h0;
                    1, 2, 3, 4: opc = 4'($urandom_range(1, 4));
                    5, 6: opc = 4'h8;
                    7, 8: opc = 4'h9;
                    default: opc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 14)) : 4'h0;
                endcase
                pq.push_back(ins(opc, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3)));
            end
            pq.push_back(ins(4'hF, 0, 0, 0));
            load_prog(); exec_prog(0);
        end

        // pc wraps past the last entry without halting
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            @(negedge clk);
            imem_we = 1'b1; imem_waddr = PC_W'(i);
            imem_wdata = (i == 0) ? ins(4'h8, 7, 2, 0) : ins(4'h0, 0, 0, 0);
            prog[i] = imem_wdata;
        end
        @(negedge clk); imem_we = 1'b0; run = 1'b1;
        @(negedge clk); run = 1'b0;
        loads = 0; pend = 0;
        for (int c = 0; c < 3000; c++) begin
            mem_done = 1'b0;
            if (mem_load && !pend) begin
                loads++;
                if (loads == 2) break;
                pend = 1;
            end else if (pend) begin
                mem_done = 1'b1; mem_rdata = 8'h5A; pend = 0;
            end
            @(negedge clk);
        end
        check("wrap_second_load", loads, 2);
        check("wrap_pc", pc, 0);
        check("wrap_addr", mem_addr, 7);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        check_outs_zero("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
